// File: rtl/mram_serial_host_if.sv
// mram_serial_host_if: frames parallel MRAM commands onto the serial addr/data lines
// of MRAM_Top_Module and deserializes read data back into 16-bit responses.
module mram_serial_host_if #(
    parameter int ADDR_W  = 20,
    parameter int DATA_W  = 16,
    parameter int RD_LAT  = 2,
    parameter int GAP_CYC = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [1:0]        cmd_be,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              cmd_err,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              link_rst,
    output logic [2:0]        read_write_sel,
    output logic              addr_in,
    output logic              data_in,
    input  logic              ser_data_out,
    output logic              busy
);
    localparam int MAXV = (ADDR_W > DATA_W ? ADDR_W : DATA_W) > (RD_LAT > GAP_CYC ? RD_LAT : GAP_CYC)
                        ? (ADDR_W > DATA_W ? ADDR_W : DATA_W) : (RD_LAT > GAP_CYC ? RD_LAT : GAP_CYC);
    localparam int CW = $clog2(MAXV + 1);
    localparam logic [CW-1:0] A_LAST = CW'(ADDR_W - 1);
    localparam logic [CW-1:0] L_LAST = CW'(RD_LAT - 1);
    localparam logic [CW-1:0] D_DONE = CW'(DATA_W);
    localparam logic [CW-1:0] G_LAST = CW'(GAP_CYC - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SETUP   = 3'd1;
    localparam logic [2:0] S_SHIFT   = 3'd2;
    localparam logic [2:0] S_RD_WAIT = 3'd3;
    localparam logic [2:0] S_RD_CAP  = 3'd4;
    localparam logic [2:0] S_GAP     = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, shreg_q, rsp_q;
    logic [1:0]        be_q;
    logic              wr_q, err_q, rsp_valid_q;
    logic              idle, frame, accept, cap_done;

    assign idle     = state_q == S_IDLE;
    assign frame    = state_q inside {S_SETUP, S_SHIFT, S_RD_WAIT, S_RD_CAP};
    assign accept   = idle && cmd_valid;
    // RD_CAP runs one extra cycle past the last sample to publish the word
    assign cap_done = state_q == S_RD_CAP && cnt_q == D_DONE;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (accept && cmd_be != 2'b00) state_d = S_SETUP;
            end
            S_SETUP: begin
                cnt_d   = '0;
                state_d = S_SHIFT;
            end
            S_SHIFT: if (cnt_q == A_LAST) begin
                cnt_d   = '0;
                state_d = wr_q ? S_GAP : S_RD_WAIT;
            end
            S_RD_WAIT: if (cnt_q == L_LAST) begin
                cnt_d   = '0;
                state_d = S_RD_CAP;
            end
            S_RD_CAP: if (cap_done) begin
                cnt_d   = '0;
                state_d = S_GAP;
            end
            S_GAP: if (cnt_q == G_LAST) begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            shreg_q     <= '0;
            rsp_q       <= '0;
            be_q        <= '0;
            wr_q        <= 1'b0;
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            err_q       <= accept && cmd_be == 2'b00;
            rsp_valid_q <= cap_done;
            if (accept) begin
                addr_q  <= cmd_addr;
                wdata_q <= cmd_wdata;
                be_q    <= cmd_be;
                wr_q    <= cmd_write;
            end else if (state_q == S_SHIFT) begin
                addr_q  <= addr_q >> 1;
                wdata_q <= wdata_q >> 1;
            end
            if (state_q == S_RD_CAP && !cap_done) shreg_q <= {shreg_q[DATA_W-2:0], ser_data_out};
            if (cap_done) rsp_q <= shreg_q & {{DATA_W/2{be_q[1]}}, {DATA_W/2{be_q[0]}}};
        end
    end

    assign cmd_ready      = idle && rst;
    assign busy           = !idle;
    assign link_rst       = !frame;
    assign read_write_sel = frame ? {be_q, wr_q} : 3'b000;
    assign addr_in        = state_q == S_SHIFT && addr_q[0];
    assign data_in        = state_q == S_SHIFT && wr_q && wdata_q[0];
    assign cmd_err        = err_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_data       = rsp_q;
endmodule

// File: doc/mram_serial_host_if.md
Name: mram_serial_host_if

Overview:
- Host-side framing stage directly upstream of MRAM_Top_Module.
- Accepts parallel MRAM commands (20-bit address, 16-bit data, byte enables, read/write) on a valid/ready handshake.
- Serializes each command LSB-first onto the top module's addr_in/data_in bit lines, driving read_write_sel and the link reset.
- For reads, deserializes ser_data_out (MSB-first) back into a 16-bit response.

Parameters:
ADDR_W, 20, address bits shifted per frame
DATA_W, 16, data bits per word
RD_LAT, 2, cycles between the last address bit and the first valid ser_data_out bit
GAP_CYC, 3, idle cycles with link_rst high between frames

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept a command (high only in IDLE)
cmd_write  in  1  1=write, 0=read
cmd_be  in  2  [1]=upper byte, [0]=lower byte
cmd_addr  in  ADDR_W  word address
cmd_wdata  in  DATA_W  write data
cmd_err  out  1  one-cycle pulse: command with cmd_be=00 rejected
rsp_valid  out  1  one-cycle pulse: rsp_data valid
rsp_data  out  DATA_W  read result
link_rst  out  1  active-high reset to MRAM_Top_Module
read_write_sel  out  3  {upper_en, lower_en, write} to MRAM_Top_Module
addr_in  out  1  serial address bit
data_in  out  1  serial write-data bit
ser_data_out  in  1  serial read data from MRAM_Top_Module
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst=0, asynchronous):
  - link_rst=1; all other outputs 0 (read_write_sel=000, rsp_data=0); state=IDLE.
  - Reset mid-frame aborts the frame; no rsp_valid or cmd_err is produced.
- States: IDLE, SETUP, SHIFT, RD_WAIT, RD_CAP, GAP.
- IDLE:
  - cmd_ready=1, link_rst=1, read_write_sel=000, addr_in=data_in=0.
  - On cmd_valid && cmd_ready: latch cmd_*.
  - If cmd_be=00: pulse cmd_err the next cycle and stay in IDLE.
  - Otherwise go to SETUP.
- SETUP (1 cycle): link_rst=0; read_write_sel={be[1],be[0],write}. read_write_sel is held constant until GAP.
- SHIFT (ADDR_W cycles, bit counter k=0..ADDR_W-1):
  - addr_in=addr[k].
  - data_in=wdata[k] when write and k<DATA_W; otherwise 0.
  - After k=ADDR_W-1: write goes to GAP; read goes to RD_WAIT.
- RD_WAIT (RD_LAT cycles): outputs as in SHIFT with addr_in=data_in=0. Then RD_CAP.
- RD_CAP (DATA_W cycles):
  - Each edge shifts ser_data_out in MSB-first: shreg <= {shreg[DATA_W-2:0], ser_data_out}.
  - After the 16th sample, rsp_data is loaded with byte masking: be=10 zeroes [7:0]; be=01 zeroes [15:8].
  - rsp_valid pulses in the same cycle rsp_data updates (1 cycle after the last sample).
  - Then GAP.
- GAP (GAP_CYC cycles): link_rst=1, read_write_sel=000, addr_in=data_in=0. Then IDLE.
- rsp_data holds its last value until the next read completes.
- Command-to-command spacing:
  - Write: 1+ADDR_W+GAP_CYC cycles from acceptance to the next cmd_ready.
  - Read: 1+ADDR_W+RD_LAT+DATA_W+1+GAP_CYC cycles.
- cmd_valid asserted outside IDLE is ignored (not latched). cmd_* inputs may change freely after acceptance.
- Counters are sized to ceil(log2(max(ADDR_W, DATA_W, RD_LAT, GAP_CYC)+1)) and reset to 0 on every state entry.

Test Plan:
1. Full write, addr=0x00000, wdata=0xAAAA, be=11 -> SETUP cycle shows sel=111, link_rst=0; over 20 SHIFT cycles addr_in is all 0, data_in=0,1,0,1,... for 16 cycles then 0 for 4; GAP of 3 cycles with link_rst=1; cmd_ready returns 24 cycles after acceptance.
2. Lower-byte write, addr=0x00001, wdata=0x0055, be=01 -> sel=011; addr_in=1 on SHIFT cycle 0 then 0; data_in=1,0,1,0,1,0,1,0,0...
3. Full read, addr=0x00002, be=11, ser_data_out driven with 0xC3A5 MSB-first starting RD_LAT cycles after the last address bit -> sel=110 throughout the frame; rsp_valid single pulse with rsp_data=0xC3A5.
4. Upper-byte read, be=10, same serial stream 0xC3A5 -> sel=100; rsp_data=0xC300. Lower-byte read, be=01 -> sel=010; rsp_data=0x00A5.
5. Command with be=00 -> one-cycle cmd_err pulse; link_rst stays 1; no SETUP entered; cmd_ready high again the following cycle.
6. rst driven low at SHIFT cycle 10 of a read -> link_rst=1, sel=000, busy=0 immediately; no rsp_valid; after release, a new full write completes normally. Back-to-back cmd_valid during busy is not accepted until cmd_ready=1.
